// File: rtl/dmem_waitstate_pkg.sv
// Shared definitions for the wait-state data memory: word width, lane count,
// wait-counter width and the FSM state encoding.
package dmem_waitstate_pkg;

    localparam int unsigned DMEM_WORD_LEN = 32;
    localparam int unsigned DMEM_LANES    = DMEM_WORD_LEN / 8;
    localparam int unsigned DMEM_CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    // Byte-lane count for an arbitrary word width.
    function automatic int unsigned lanes_of(input int unsigned word_len);
        return word_len / 8;
    endfunction

endpackage

// File: rtl/dmem_waitstate_if.sv
// CPU-side request/response bundle of the data memory. The CPU drives the
// master modport and the memory implements the slave modport.
interface dmem_waitstate_if #(
    parameter int unsigned WORD_LEN = dmem_waitstate_pkg::DMEM_WORD_LEN
);
    import dmem_waitstate_pkg::*;

    localparam int unsigned LANES = lanes_of(WORD_LEN);

    logic                readEN;
    logic                writeEN;
    logic [LANES-1:0]    byteEN;
    logic [WORD_LEN-1:0] address;
    logic [WORD_LEN-1:0] dataIn;
    logic [WORD_LEN-1:0] dataOut;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output readEN, writeEN, byteEN, address, dataIn,
        input  dataOut, busy, done, err
    );

    modport slave (
        input  readEN, writeEN, byteEN, address, dataIn,
        output dataOut, busy, done, err
    );

endinterface

// File: rtl/dmem_waitstate_array.sv
// Storage for the data memory: DEPTH x WORD_LEN words with async clear,
// byte-lane write port and a registered read port.
module dmem_waitstate_array
    import dmem_waitstate_pkg::*;
#(
    parameter int unsigned WORD_LEN = DMEM_WORD_LEN,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned IDX_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wr_en,
    input  logic                          i_rd_en,
    input  logic                          i_rd_zero,
    input  logic [IDX_W-1:0]              i_idx,
    input  logic [lanes_of(WORD_LEN)-1:0] i_be,
    input  logic [WORD_LEN-1:0]           i_wdata,
    output logic [WORD_LEN-1:0]           o_rdata
);

    localparam int unsigned LANES = lanes_of(WORD_LEN);

    logic [WORD_LEN-1:0] r_mem [DEPTH];
    logic [WORD_LEN-1:0] r_rdata;

    // Word storage; only the enabled byte lanes of the addressed word change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            for (int l = 0; l < int'(LANES); l++) begin
                if (i_be[l]) begin
                    r_mem[i_idx][l*8 +: 8] <= i_wdata[l*8 +: 8];
                end
            end
        end
    end

    // Read register; an out-of-range read returns zero instead of array data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= i_rd_zero ? '0 : r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_waitstate.sv
// Data memory with configurable wait states and a busy/done/err handshake;
// holds the FSM, wait counter and operand latches around the storage array.
module dmem_waitstate
    import dmem_waitstate_pkg::*;
#(
    parameter int unsigned WORD_LEN    = DMEM_WORD_LEN,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic           clk,
    input  logic           rst,
    dmem_waitstate_if.slave io_bus
);

    localparam int unsigned          LANES = lanes_of(WORD_LEN);
    localparam int unsigned          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WORD_LEN-1:0]  BASE  = WORD_LEN'(BASE_ADDR);
    localparam logic [WORD_LEN-1:0]  WORDS = WORD_LEN'(DEPTH);

    // Out of range when below the base or past the last stored word.
    function automatic logic addr_oor(input logic [WORD_LEN-1:0] a);
        logic [WORD_LEN-1:0] off;
        off = (a - BASE) >> 2;
        return (a < BASE) || (off >= WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [WORD_LEN-1:0] a);
        logic [WORD_LEN-1:0] off;
        off = (a - BASE) >> 2;
        return off[IDX_W-1:0];
    endfunction

    dmem_state_e           r_state;
    dmem_state_e           w_state_nxt;
    logic [DMEM_CNT_W-1:0] r_cnt;
    logic [DMEM_CNT_W-1:0] w_cnt_nxt;

    logic [WORD_LEN-1:0]   r_addr;
    logic [WORD_LEN-1:0]   r_din;
    logic [LANES-1:0]      r_be;
    logic                  r_wr;
    logic                  r_conflict;
    logic                  r_done;
    logic                  r_err;

    logic                  w_req;
    logic                  w_accept;
    logic                  w_access;
    logic [WORD_LEN-1:0]   w_addr;
    logic [WORD_LEN-1:0]   w_din;
    logic [LANES-1:0]      w_be;
    logic                  w_wr;
    logic                  w_conflict;
    logic                  w_oor;
    logic [WORD_LEN-1:0]   w_rdata;

    assign w_req = io_bus.readEN | io_bus.writeEN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, counter and access strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = DMEM_CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        w_access    = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nxt = r_cnt - DMEM_CNT_W'(1);
                if (r_cnt == DMEM_CNT_W'(1)) begin
                    w_access    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Zero-wait accesses complete on the accept edge, before the latches load.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_addr     = io_bus.address;
            w_din      = io_bus.dataIn;
            w_be       = io_bus.byteEN;
            w_wr       = io_bus.writeEN;
            w_conflict = io_bus.readEN & io_bus.writeEN;
        end else begin
            w_addr     = r_addr;
            w_din      = r_din;
            w_be       = r_be;
            w_wr       = r_wr;
            w_conflict = r_conflict;
        end
    end

    assign w_oor = addr_oor(w_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_din      <= '0;
            r_be       <= '0;
            r_wr       <= 1'b0;
            r_conflict <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= io_bus.address;
            r_din      <= io_bus.dataIn;
            r_be       <= io_bus.byteEN;
            r_wr       <= io_bus.writeEN;
            r_conflict <= io_bus.readEN & io_bus.writeEN;
        end
    end

    // Completion pulse; err is only ever set alongside done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_access;
            r_err  <= w_access & (w_oor | w_conflict);
        end
    end

    dmem_waitstate_array #(
        .WORD_LEN (WORD_LEN),
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_access & w_wr & ~w_oor),
        .i_rd_en   (w_access & ~w_wr),
        .i_rd_zero (w_oor),
        .i_idx     (addr_idx(w_addr)),
        .i_be      (w_be),
        .i_wdata   (w_din),
        .o_rdata   (w_rdata)
    );

    assign io_bus.busy    = ~rst & (((r_state == ST_IDLE) & w_req) | (r_state == ST_WAIT));
    assign io_bus.done    = r_done;
    assign io_bus.err     = r_err;
    assign io_bus.dataOut = w_rdata;

endmodule

// File: doc/dmem_waitstate.md
Name: dmem_waitstate

Overview:
- Parametrised data-memory model for the pipelined MIPS CPU, replacing the fixed single-cycle data memory.
- Adds byte-lane writes, a configurable access latency (wait states), and a busy/done handshake that stalls the pipeline.
- Adds an error flag for out-of-range or conflicting requests.
- Sits between the CPU MEM stage (ALU_Result as address, Store_Value as write data) and the testbench. It is synthesisable enough to be used as a cache-miss stand-in.

Parameters:
- WORD_LEN, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 256, number of words stored.
- BASE_ADDR, 0, byte address mapped to word 0.
- WAIT_STATES, 2, extra cycles before an access completes; range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- readEN  input  1  read request; held by the CPU while busy is high.
- writeEN  input  1  write request; held by the CPU while busy is high.
- byteEN  input  WORD_LEN/8  write lane enables; bit i selects bits [8i+7:8i]; ignored on reads.
- address  input  WORD_LEN  byte address.
- dataIn  input  WORD_LEN  write data.
- dataOut  output  WORD_LEN  registered read data.
- busy  output  1  stall request to the CPU.
- done  output  1  one-cycle completion pulse.
- err  output  1  error qualifier; valid only while done is high.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, dataOut=0, done=0, err=0, wait counter=0, all DEPTH words=0. A request in flight is discarded; a pending write never commits.
- Address decode: word index = (address - BASE_ADDR) >> 2; address[1:0] are ignored. The address is out of range if address < BASE_ADDR or index >= DEPTH.
- FSM states: IDLE, WAIT, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, readEN or writeEN high: latch address, dataIn, byteEN and operation. Load the counter with WAIT_STATES.
  - If WAIT_STATES = 0, perform the access on this edge and go to DONE.
  - Otherwise go to WAIT.
- WAIT: decrement the counter each cycle. On the edge where the counter is 1, perform the access and go to DONE.
- Access, write: commit only the enabled lanes; dataOut is unchanged.
- Access, read: dataOut <= word at the latched index.
- Access outcome: done <= 1. err <= out-of-range, or both enables were high.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally. Request inputs are ignored in DONE because they belong to the request just completed.
- busy (combinational) = (state==IDLE and (readEN or writeEN)) or state==WAIT. busy is low in DONE.
- Latency: a request presented in cycle 0 gives done and dataOut valid in cycle WAIT_STATES+1. The next request is accepted no earlier than cycle WAIT_STATES+2.
- readEN and writeEN both high: treated as a write and err=1.
- Out-of-range access: write suppressed, read returns dataOut=0, err=1.
- byteEN=0 on a write: no storage change, done still pulses, err=0.
- Input changes after acceptance have no effect, because operands are latched.
- Read-after-write to the same word returns the merged new value.
- Reset asserted in WAIT: outputs and storage clear immediately (asynchronously). After release, the FSM restarts in IDLE.
- done and err are registered. err=0 whenever done=0.

Decomposition:
- Shared package/define file holds WORD_LEN, the state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), and the byte-lane count WORD_LEN/8.
- The address/range helper is local to this module.
- One sub-module, dmem_array, provides the storage: DEPTH x WORD_LEN, async clear, byte-lane write port, synchronous registered read.
- dmem_waitstate keeps the FSM, the counter, the operand latches and the handshake logic.

Test Plan:
- Reset then WAIT_STATES=2: write 0xDEADBEEF to address 0x10 with byteEN=4'hF. Expect busy high in cycles 0-2, done in cycle 3, err=0. A subsequent read of 0x10 returns 0xDEADBEEF, with done 3 cycles after the request.
- Byte lanes: with word 0x10 = 0xDEADBEEF, write 0x11223344 with byteEN=4'b0101. A read returns 0xDE22BE44.
- Range/conflict: with DEPTH=256, reading address 0x400 gives dataOut=0, err=1 with done. readEN=writeEN=1 to 0x20 with dataIn=0x5 writes 0x5 and gives err=1.
- Zero latency (WAIT_STATES=0): back-to-back read requests complete with done in cycle 1, and the next request is accepted in cycle 2. busy is high only in the accept cycle.
- Reset mid-operation: start a write of 0xA5A5A5A5 to 0x8, assert rst in cycle 1. Expect busy=0, done=0, dataOut=0 at once. After release, a read of 0x8 returns 0.
- Held request: keep readEN high through DONE. Exactly one done pulse occurs per accepted request, and a new access starts in the following IDLE cycle.
